// File: rtl/johnson_pkg.sv
// Shared constants and types for the Johnson counter block: seven-segment
// glyphs, width limits and the load-code classification record.
package johnson_pkg;

    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned IDX_W     = 5;

    // Active-low gfedcba glyphs, element [n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_CODES = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_STEP,
        OP_LOAD
    } op_t;

    typedef struct packed {
        logic             legal;
        logic [IDX_W-1:0] step;
    } code_info_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex digit to active-low gfedcba seven-segment decode.
module hex_to_7seg
    import johnson_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_CODES[digit];

endmodule

// File: rtl/johnson_nbit.sv
// Bidirectional WIDTH-bit Johnson counter with step index, wrap pulse,
// checked synchronous load and two hex displays of the step index.
module johnson_nbit
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [IDX_W-1:0] idx,
    output logic             wrap,
    output logic             err,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("johnson_nbit: WIDTH must be in 2..16");
    end

    // A code is legal only if it equals the code of some step k; that k is the index.
    function automatic code_info_t classify(input logic [WIDTH-1:0] code);
        code_info_t       info;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] cand;
        info = '0;
        ones = '1;
        for (int unsigned k = 0; k < 2 * WIDTH; k++) begin
            if (k <= WIDTH) cand = ones >> (WIDTH - k);
            else            cand = ~(ones >> (2 * WIDTH - k));
            if (!info.legal && code == cand) begin
                info.legal = 1'b1;
                info.step  = IDX_W'(k);
            end
        end
        return info;
    endfunction

    op_t              op;
    code_info_t       info;
    logic [WIDTH-1:0] q_next;
    logic [IDX_W-1:0] idx_next;
    logic             wrap_next;
    logic             err_next;

    always_comb begin
        op = OP_HOLD;
        if (load)    op = OP_LOAD;
        else if (en) op = OP_STEP;
    end

    always_comb begin
        info      = classify(load_val);
        q_next    = q;
        idx_next  = idx;
        wrap_next = 1'b0;
        err_next  = err;
        case (op)
            OP_LOAD: begin
                if (info.legal) begin
                    q_next   = load_val;
                    idx_next = info.step;
                    err_next = 1'b0;
                end else begin
                    q_next   = '0;
                    idx_next = '0;
                    err_next = 1'b1;
                end
            end
            OP_STEP: begin
                if (!dir) begin
                    q_next    = {q[WIDTH-2:0], ~q[WIDTH-1]};
                    wrap_next = (idx == LAST_IDX);
                    idx_next  = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                end else begin
                    q_next    = {~q[0], q[WIDTH-1:1]};
                    wrap_next = (idx == '0);
                    idx_next  = (idx == '0) ? LAST_IDX : idx - IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            idx  <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            q    <= q_next;
            idx  <= idx_next;
            wrap <= wrap_next;
            err  <= err_next;
        end
    end

    hex_to_7seg u_hex0 (
        .digit (idx[3:0]),
        .seg   (HEX0)
    );

    hex_to_7seg u_hex1 (
        .digit ({3'b000, idx[4]}),
        .seg   (HEX1)
    );

endmodule

// File: tb/tb_johnson_nbit.sv
// Bench for johnson_nbit: directed vector table at WIDTH=8, a WIDTH=12
// period run, and random traffic on both widths against a step-index model.
module tb_johnson_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, dir, load;
    logic [7:0]  lv8;
    logic [11:0] lv12;

    logic [7:0]  q8;
    logic [4:0]  idx8;
    logic        wrap8, err8;
    logic [6:0]  h0_8, h1_8;
    logic [11:0] q12;
    logic [4:0]  idx12;
    logic        wrap12, err12;
    logic [6:0]  h0_12, h1_12;

    johnson_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv8),
        .q(q8), .idx(idx8), .wrap(wrap8), .err(err8), .HEX0(h0_8), .HEX1(h1_8)
    );

    johnson_nbit #(.WIDTH(12)) dut12 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv12),
        .q(q12), .idx(idx12), .wrap(wrap12), .err(err12), .HEX0(h0_12), .HEX1(h1_12)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: step index, error flag and wrap pulse per instance.
    int mw [2] = '{8, 12};
    int mk [2];
    int merr [2];
    int mwrap [2];

    function automatic int code_of(int w, int k);
        if (k <= w) return (1 << k) - 1;
        return ((1 << w) - 1) - ((1 << (k - w)) - 1);
    endfunction

    function automatic int step_of(int w, int v);
        for (int k = 0; k < 2 * w; k++)
            if (code_of(w, k) == v) return k;
        return -1;
    endfunction

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int i, input int lv);
        int p, s;
        p = 2 * mw[i];
        if (reset) begin
            mk[i] = 0; merr[i] = 0; mwrap[i] = 0;
        end else if (load) begin
            s = step_of(mw[i], lv);
            mwrap[i] = 0;
            if (s < 0) begin mk[i] = 0; merr[i] = 1; end
            else       begin mk[i] = s; merr[i] = 0; end
        end else if (en) begin
            if (!dir) begin
                mwrap[i] = (mk[i] == p - 1);
                mk[i] = (mk[i] + 1) % p;
            end else begin
                mwrap[i] = (mk[i] == 0);
                mk[i] = (mk[i] + p - 1) % p;
            end
        end else begin
            mwrap[i] = 0;
        end
    endtask

    task automatic edge_and_model();
        @(posedge clk);
        #1;
        model_edge(0, int'(lv8));
        model_edge(1, int'(lv12));
    endtask

    task automatic check_model(input bit with8);
        if (with8) begin
            chk("m_q8", 32'(q8), code_of(8, mk[0]));
            chk("m_idx8", 32'(idx8), mk[0]);
            chk("m_wrap8", 32'(wrap8), mwrap[0]);
            chk("m_err8", 32'(err8), merr[0]);
            chk("m_hex0_8", 32'(h0_8), 32'(seg_of(mk[0] % 16)));
            chk("m_hex1_8", 32'(h1_8), 32'(seg_of(mk[0] / 16)));
        end
        chk("m_q12", 32'(q12), code_of(12, mk[1]));
        chk("m_idx12", 32'(idx12), mk[1]);
        chk("m_wrap12", 32'(wrap12), mwrap[1]);
        chk("m_err12", 32'(err12), merr[1]);
        chk("m_hex0_12", 32'(h0_12), 32'(seg_of(mk[1] % 16)));
        chk("m_hex1_12", 32'(h1_12), 32'(seg_of(mk[1] / 16)));
    endtask

    typedef struct {
        bit         rst, en, dir, ld;
        logic [7:0] lv;
        logic [7:0] eq;
        logic [4:0] eidx;
        bit         ew, ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit e, input bit d, input bit l, input logic [7:0] lv,
                       input logic [7:0] eq, input logic [4:0] ei, input bit ew, input bit ee);
        vec_t v;
        v.rst = r; v.en = e; v.dir = d; v.ld = l; v.lv = lv;
        v.eq = eq; v.eidx = ei; v.ew = ew; v.ee = ee;
        tbl.push_back(v);
    endtask

    logic [7:0] fwd_q [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                              8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; lv8 = '0; lv12 = '0;
        foreach (mk[i]) begin mk[i] = 0; merr[i] = 0; mwrap[i] = 0; end

        // Full forward period from reset.
        add(1,0,0,0,8'h00, 8'h00,5'd0,0,0);
        for (int i = 0; i < 16; i++) add(0,1,0,0,8'h00, fwd_q[i],5'((i + 1) % 16),i == 15,0);
        // Backward from reset wraps immediately.
        add(1,0,0,0,8'h00, 8'h00,5'd0,0,0);
        add(0,1,1,0,8'h00, 8'h80,5'd15,1,0);
        add(0,1,1,0,8'h00, 8'hC0,5'd14,0,0);
        add(0,1,1,0,8'h00, 8'hE0,5'd13,0,0);
        // Loads, hold, sticky error, load over en, reset over load.
        add(0,0,0,1,8'h3F, 8'h3F,5'd6,0,0);
        add(0,0,1,0,8'h00, 8'h3F,5'd6,0,0);
        add(0,0,0,1,8'h55, 8'h00,5'd0,0,1);
        add(0,1,0,0,8'h00, 8'h01,5'd1,0,1);
        add(0,1,0,0,8'h00, 8'h03,5'd2,0,1);
        add(0,1,1,1,8'hF0, 8'hF0,5'd12,0,0);
        add(1,1,0,1,8'h3F, 8'h00,5'd0,0,0);
        add(0,0,0,1,8'h81, 8'h00,5'd0,0,1);
        add(1,0,0,0,8'h00, 8'h00,5'd0,0,0);
        // Count to idx 9, then reset mid-count with en still high.
        for (int i = 0; i < 9; i++) add(0,1,0,0,8'h00, fwd_q[i],5'(i + 1),0,0);
        add(1,1,0,0,8'h00, 8'h00,5'd0,0,0);
        // Direction changes every cycle without a bubble, then hold.
        add(0,1,0,0,8'h00, 8'h01,5'd1,0,0);
        add(0,1,0,0,8'h00, 8'h03,5'd2,0,0);
        add(0,1,1,0,8'h00, 8'h01,5'd1,0,0);
        add(0,1,0,0,8'h00, 8'h03,5'd2,0,0);
        add(0,0,0,0,8'h00, 8'h03,5'd2,0,0);
        // Backward across zero, then forward back across the wrap point.
        add(0,1,1,0,8'h00, 8'h01,5'd1,0,0);
        add(0,1,1,0,8'h00, 8'h00,5'd0,0,0);
        add(0,1,1,0,8'h00, 8'h80,5'd15,1,0);
        add(0,1,0,0,8'h00, 8'h00,5'd0,1,0);
        // Boundary legal codes.
        add(0,0,0,1,8'hFF, 8'hFF,5'd8,0,0);
        add(0,0,0,1,8'h80, 8'h80,5'd15,0,0);
        add(0,1,0,0,8'h00, 8'h00,5'd0,1,0);
        add(0,0,0,1,8'h00, 8'h00,5'd0,0,0);

        foreach (tbl[r]) begin
            reset = tbl[r].rst; en = tbl[r].en; dir = tbl[r].dir; load = tbl[r].ld;
            lv8 = tbl[r].lv;
            lv12 = 12'($urandom_range(0, 4095));
            edge_and_model();
            chk("tbl_q8", 32'(q8), 32'(tbl[r].eq));
            chk("tbl_idx8", 32'(idx8), 32'(tbl[r].eidx));
            chk("tbl_wrap8", 32'(wrap8), 32'(tbl[r].ew));
            chk("tbl_err8", 32'(err8), 32'(tbl[r].ee));
            chk("tbl_hex0_8", 32'(h0_8), 32'(seg_of(int'(tbl[r].eidx[3:0]))));
            chk("tbl_hex1_8", 32'(h1_8), 32'(seg_of(int'(tbl[r].eidx[4]))));
            check_model(1'b0);
        end

        // WIDTH=12: two forward periods of 24 steps from reset.
        reset = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0;
        edge_and_model();
        check_model(1'b1);
        reset = 1'b0; en = 1'b1;
        for (int n = 1; n <= 48; n++) begin
            edge_and_model();
            chk("p12_idx", 32'(idx12), n % 24);
            chk("p12_wrap", 32'(wrap12), 32'(n % 24 == 0));
            if (n % 24 == 23) begin
                chk("p12_hex1_at17", 32'(h1_12), 32'(7'b1111001));
                chk("p12_hex0_at17", 32'(h0_12), 32'(7'b1111000));
            end
            check_model(1'b1);
        end

        // Random traffic on both widths.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            dir   = 1'($urandom_range(0, 1));
            lv8   = $urandom_range(0, 1) ? 8'(code_of(8, $urandom_range(0, 15)))
                                         : 8'($urandom_range(0, 255));
            lv12  = $urandom_range(0, 1) ? 12'(code_of(12, $urandom_range(0, 23)))
                                         : 12'($urandom_range(0, 4095));
            edge_and_model();
            check_model(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/johnson_nbit.md
JOHNSON_NBIT -- requirements
Module: johnson_nbit

Interface
REQ-001 Parameter WIDTH, default 8, legal 2..16; sets the counter register width and the 2*WIDTH-step period.
REQ-002 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port en, input, 1: advance one step per cycle when high.
REQ-005 Port dir, input, 1: direction; 0 = forward (shift left), 1 = backward (shift right).
REQ-006 Port load, input, 1: synchronous load strobe.
REQ-007 Port load_val, input, WIDTH: candidate code for load.
REQ-008 Port q, output, WIDTH: registered counter state.
REQ-009 Port idx, output, 5: registered step index 0..2*WIDTH-1; zero-extended.
REQ-010 Port wrap, output, 1: registered one-cycle pulse on period completion.
REQ-011 Port err, output, 1: sticky flag for an illegal load.
REQ-012 Ports HEX0 and HEX1, outputs, 7 each: active-low seven-segment displays, bit order gfedcba; HEX0 = idx[3:0], HEX1 = {3'b000, idx[4]} in hex.

Function
REQ-013 Legal code for step k: k<=WIDTH -> lower k bits 1, rest 0; k>WIDTH -> lower k-WIDTH bits 0, rest 1.
REQ-014 Update priority per edge: reset > load > en > hold.
REQ-015 Forward step (en=1, dir=0, load=0):
- q <= {q[WIDTH-2:0], ~q[WIDTH-1]}
- idx <= idx+1, wrapping 2*WIDTH-1 -> 0
REQ-016 Backward step (en=1, dir=1, load=0):
- q <= {~q[0], q[WIDTH-1:1]}
- idx <= idx-1, wrapping 0 -> 2*WIDTH-1
REQ-017 With en=0 and load=0, q and idx hold and wrap is 0.
REQ-018 wrap is 1 in the cycle after any step that wraps idx (forward 2*WIDTH-1 -> 0, or backward 0 -> 2*WIDTH-1); otherwise 0.
REQ-019 Legal load: q <= load_val, idx <= its step k, err <= 0, wrap <= 0.
REQ-020 Illegal load: q <= 0, idx <= 0, err <= 1, wrap <= 0.
REQ-021 err stays 1 through counting until a reset or a legal load.
REQ-022 q and idx stay consistent per REQ-013 at every cycle boundary.
REQ-023 dir may change on any cycle; the next step uses the new dir, with no bubble.
REQ-024 HEX0 and HEX1 are combinational decodes of registered idx; no added latency.

Reset
REQ-025 reset=1 at an edge forces q=0, idx=0, wrap=0 and err=0, overriding load and en; this includes reset mid-count.
REQ-026 After reset, HEX0 = HEX1 = 7'b1000000 ("0").

Structure
REQ-027 Shared package johnson_pkg holds:
- segment code constants for hex 0..F, active-low gfedcba
- max WIDTH constant (16)
- index width constant (5)
REQ-028 One sub-module, hex_to_7seg (4-bit in, 7-bit active-low out), is instantiated twice.
REQ-029 The legality check and the code-to-index conversion are a combinational function inside johnson_nbit.

Verification
REQ-030 WIDTH=8, reset, en=1, dir=0 for 16 edges -> q = 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00; idx 0..F then 0; wrap high exactly once, after edge 16; HEX0 tracks idx.
REQ-031 WIDTH=8, from reset, en=1, dir=1 -> q = 00,80,C0,E0; idx = 0,F,E,D; wrap high after edge 1 only.
REQ-032 WIDTH=8, load=1, load_val=0x3F -> q=3F, idx=6, err=0, HEX0=7'b0000010, HEX1=7'b1000000.
REQ-033 WIDTH=8, load_val=0x55 with load=1 -> q=00, idx=0, err=1; with en=1 the count proceeds and err stays 1; a legal load of 0xF0 -> idx=C, err=0.
REQ-034 Simultaneous events:
- load=1 and en=1 -> load result only
- reset=1 and load=1 -> reset values
- reset asserted at idx=9 -> all outputs reset next cycle
REQ-035 WIDTH=12, forward from reset -> period 24, wrap every 24 cycles; at idx=0x17, HEX1=7'b1111001 ("1") and HEX0=7'b1111000 ("7").
